// File: rtl/buffer_writer_if.sv
// Packet-buffer writer bus: byte ingress stream, buffer RAM write port,
// consumer read pointer and descriptor handshake.
//
// Handshake rule for both streams (in_valid/in_ready, desc_valid/desc_ready):
// a transfer happens on a rising clk edge where valid and ready are both 1;
// the source holds its payload stable while valid is high and not yet taken,
// and ready may depend combinationally on state but never on valid.
interface buffer_writer_if #(
   parameter int ADDR_W = 14,
   parameter int LEN_W  = 16
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr_wr;
   logic [31:0]       mem_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] desc_start;
   logic [LEN_W-1:0]  desc_len;
   logic [15:0]       desc_csum;
   logic              desc_valid;
   logic              desc_ready;

   // Producer / consumer side of the writer.
   modport master (
      output in_data, in_valid, in_last, rd_ptr, desc_ready,
      input  in_ready, mem_addr_wr, mem_data, mem_wr_en,
             desc_start, desc_len, desc_csum, desc_valid
   );

   // The writer itself.
   modport slave (
      input  in_data, in_valid, in_last, rd_ptr, desc_ready,
      output in_ready, mem_addr_wr, mem_data, mem_wr_en,
             desc_start, desc_len, desc_csum, desc_valid
   );
endinterface

// File: rtl/buffer_writer.sv
// buffer_writer: packs an ingress byte stream big-endian into 32-bit words of
// a circular packet buffer and emits one descriptor (start word, byte length,
// checksum) per packet. Optional checksum: define BUFFER_WRITER_CSUM_EN.
module buffer_writer #(
   parameter int ADDR_W = 14,
   parameter int LEN_W  = 16
) (
   input  logic           clk,
   input  logic           reset,
   buffer_writer_if.slave bus,
   output logic [1:0]     dbg_state_o
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RECV = 2'd1;
   localparam logic [1:0] DESC = 2'd2;
   localparam logic [LEN_W-1:0]  LEN_MAX  = {LEN_W{1'b1}};
   localparam logic [ADDR_W-1:0] FREE_MIN = ADDR_W'(2);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0]        lane_q, lane_d;
   logic [23:0]       word_q, word_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic              desc_valid_q, desc_valid_d;
   logic              mem_wr_en_q, mem_wr_en_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_data_q, mem_data_d;

   logic [ADDR_W-1:0] used, free;
   logic              ready, accept, keep;
   logic [LEN_W-1:0]  cnt_base;
   logic [31:0]       cur_word;

   // Free space leaves one slot unused so full and empty stay distinguishable;
   // two free words are required because one may be committed next cycle.
   assign used     = wr_ptr_q - bus.rd_ptr;
   assign free     = {ADDR_W{1'b1}} - used;
   assign ready    = !reset && (state_q != DESC) && (free >= FREE_MIN);
   assign accept   = bus.in_valid && ready;
   // A new packet counts from zero; bytes past the saturated count are dropped.
   assign cnt_base = (state_q == IDLE) ? '0 : cnt_q;
   assign keep     = (cnt_base != LEN_MAX);

   // Current word with the incoming byte merged into its lane.
   always_comb begin
      cur_word = {word_q, 8'h00};
      case (lane_q)
         2'd0:    cur_word[31:24] = bus.in_data;
         2'd1:    cur_word[23:16] = bus.in_data;
         2'd2:    cur_word[15:8]  = bus.in_data;
         default: cur_word[7:0]   = bus.in_data;
      endcase
   end

   // Next-state logic: FSM, byte packing, word commit and descriptor handshake.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      lane_d       = lane_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      start_d      = start_q;
      desc_valid_d = desc_valid_q;
      mem_wr_en_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;

      if (accept) begin
         if (state_q == IDLE) begin
            start_d = wr_ptr_q;
            cnt_d   = '0;
         end
         state_d = bus.in_last ? DESC : RECV;
         if (keep) begin
            cnt_d = cnt_base + LEN_W'(1);
            if (lane_q == 2'd3 || bus.in_last) begin
               mem_wr_en_d = 1'b1;
               mem_data_d  = cur_word;
               word_d      = '0;
               lane_d      = 2'd0;
            end else begin
               word_d = cur_word[31:8];
               lane_d = lane_q + 2'd1;
            end
         end else if (bus.in_last && lane_q != 2'd0) begin
            // Saturated packet still flushes the partially filled last word.
            mem_wr_en_d = 1'b1;
            mem_data_d  = {word_q, 8'h00};
            word_d      = '0;
            lane_d      = 2'd0;
         end
      end

      if (mem_wr_en_d) begin
         mem_addr_d = wr_ptr_q;
         wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      end

      // First DESC cycle lets the last word land; descriptor is offered next.
      if (state_q == DESC) begin
         if (!desc_valid_q) begin
            desc_valid_d = 1'b1;
         end else if (bus.desc_ready) begin
            desc_valid_d = 1'b0;
            state_d      = IDLE;
         end
      end
   end

   // State registers; reset discards any partial packet or pending descriptor.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         lane_q       <= 2'd0;
         word_q       <= '0;
         cnt_q        <= '0;
         start_q      <= '0;
         desc_valid_q <= 1'b0;
         mem_wr_en_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         lane_q       <= lane_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         start_q      <= start_d;
         desc_valid_q <= desc_valid_d;
         mem_wr_en_q  <= mem_wr_en_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
      end
   end

`ifdef BUFFER_WRITER_CSUM_EN
   logic [15:0] csum_q, csum_d, csum_base, csum_add;
   logic [16:0] csum_sum;

   // One's-complement sum over big-endian 16-bit words; even bytes are high.
   always_comb begin
      csum_base = (state_q == IDLE) ? 16'h0000 : csum_q;
      csum_add  = cnt_base[0] ? {8'h00, bus.in_data} : {bus.in_data, 8'h00};
      csum_sum  = {1'b0, csum_base} + {1'b0, csum_add};
      csum_d    = csum_q;
      if (accept && keep) begin
         csum_d = csum_sum[15:0] + {15'd0, csum_sum[16]};
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum_q <= 16'h0000;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign bus.desc_csum = csum_q;
`else
   assign bus.desc_csum = 16'h0000;
`endif

   assign bus.in_ready    = ready;
   assign bus.mem_wr_en   = mem_wr_en_q;
   assign bus.mem_addr_wr = mem_addr_q;
   assign bus.mem_data    = mem_data_q;
   assign bus.desc_valid  = desc_valid_q;
   assign bus.desc_start  = start_q;
   assign bus.desc_len    = cnt_q;
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_buffer_writer.sv
// Directed bench for buffer_writer. The buffer is built with an 8-bit word
// address and 8-bit length field so the full-buffer, wrap and saturation
// corners (253/254/255 -> 0, length 255) are reached in a few thousand cycles.
module tb_buffer_writer;
   localparam int AW = 8;
   localparam int LW = 8;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DESC = 2'd2;
`ifdef BUFFER_WRITER_CSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;
   int         n_checks;
   int         n_fail;
   logic [AW+31:0]   wr_log[$];
   logic [AW+LW-1:0] desc_log[$];
   logic       cnt_en;
   int         rdy_low;

   buffer_writer_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

   buffer_writer #(.ADDR_W(AW), .LEN_W(LW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Observers: RAM writes, completed descriptors, in_ready-low cycles.
   always @(negedge clk) begin
      if (bus.mem_wr_en === 1'b1) wr_log.push_back({bus.mem_addr_wr, bus.mem_data});
      if (bus.desc_valid === 1'b1 && bus.desc_ready === 1'b1)
         desc_log.push_back({bus.desc_start, bus.desc_len});
      if (cnt_en && bus.in_ready !== 1'b1) rdy_low++;
   end

   function automatic logic [15:0] exp_csum(input logic [15:0] v);
      return CSUM_ON ? v : 16'h0000;
   endfunction

   // Driver: present one byte at a negedge, return at the negedge after it is taken.
   task automatic send_byte(input logic [7:0] b, input logic last);
      int t;
      t = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_checks++; n_fail++;
         $display("FAIL send_byte_timeout: in_ready=%b expected 1", bus.in_ready);
      end else begin
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_idle;
      int t;
      t = 0;
      while ((dbg_state !== ST_IDLE || bus.desc_valid !== 1'b0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL wait_idle_timeout: state=%0d expected %0d", dbg_state, ST_IDLE);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.desc_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      wr_log.delete();
      desc_log.delete();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
      bus.rd_ptr = '0; bus.desc_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      n_checks++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr_en: got %b expected 0", bus.mem_wr_en); end
      n_checks++; if (bus.mem_addr_wr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00", bus.mem_addr_wr); end
      n_checks++; if (bus.mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_data: got %h expected 0", bus.mem_data); end
      n_checks++; if (bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_desc_valid: got %b expected 0", bus.desc_valid); end
      n_checks++; if (bus.desc_start !== 8'h00) begin n_fail++; $display("FAIL reset_desc_start: got %h expected 00", bus.desc_start); end
      n_checks++; if (bus.desc_len !== 8'h00) begin n_fail++; $display("FAIL reset_desc_len: got %h expected 00", bus.desc_len); end
      n_checks++; if (bus.desc_csum !== 16'h0) begin n_fail++; $display("FAIL reset_desc_csum: got %h expected 0000", bus.desc_csum); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", bus.in_ready); end
      wr_log.delete();
      desc_log.delete();
   endtask

   task automatic test_basic;
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b0);
      n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr_wr !== 8'd0 || bus.mem_data !== 32'h01020304) begin n_fail++; $display("FAIL basic_word0: got en=%b addr=%h data=%h expected 1/00/01020304", bus.mem_wr_en, bus.mem_addr_wr, bus.mem_data); end
      send_byte(8'h05, 1'b1);
      n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr_wr !== 8'd1 || bus.mem_data !== 32'h05000000) begin n_fail++; $display("FAIL basic_word1: got en=%b addr=%h data=%h expected 1/01/05000000", bus.mem_wr_en, bus.mem_addr_wr, bus.mem_data); end
      n_checks++; if (bus.desc_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_n1: got desc_valid=%b in_ready=%b expected 0/0", bus.desc_valid, bus.in_ready); end
      @(negedge clk);
      n_checks++; if (bus.desc_valid !== 1'b1) begin n_fail++; $display("FAIL basic_desc_valid: got %b expected 1", bus.desc_valid); end
      n_checks++; if (bus.desc_start !== 8'd0 || bus.desc_len !== 8'd5) begin n_fail++; $display("FAIL basic_desc: got start=%0d len=%0d expected 0/5", bus.desc_start, bus.desc_len); end
      n_checks++; if (bus.desc_csum !== exp_csum(16'h0906)) begin n_fail++; $display("FAIL basic_csum: got %h expected %h", bus.desc_csum, exp_csum(16'h0906)); end
      bus.desc_ready = 1'b1;
      @(negedge clk);
      bus.desc_ready = 1'b0;
      n_checks++; if (bus.desc_valid !== 1'b0 || dbg_state !== ST_IDLE || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: got valid=%b state=%0d ready=%b expected 0/0/1", bus.desc_valid, dbg_state, bus.in_ready); end
      #1;
      n_checks++; if (wr_log.size() != 2) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 2", wr_log.size()); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      bus.desc_ready = 1'b1;
      rdy_low = 0;
      cnt_en = 1'b1;
      send_byte(8'hA0, 1'b0); send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0); send_byte(8'hA3, 1'b1);
      send_byte(8'hB0, 1'b0); send_byte(8'hB1, 1'b0); send_byte(8'hB2, 1'b0); send_byte(8'hB3, 1'b1);
      wait_idle();
      cnt_en = 1'b0;
      bus.desc_ready = 1'b0;
      #1;
      n_checks++; if (rdy_low != 4) begin n_fail++; $display("FAIL b2b_ready_low_cycles: got %0d expected 4", rdy_low); end
      n_checks++; if (desc_log.size() != 2) begin n_fail++; $display("FAIL b2b_desc_count: got %0d expected 2", desc_log.size()); end
      n_checks++; if (desc_log[0] !== {8'd0, 8'd4}) begin n_fail++; $display("FAIL b2b_desc0: got %h expected 0004", desc_log[0]); end
      n_checks++; if (desc_log[1] !== {8'd1, 8'd4}) begin n_fail++; $display("FAIL b2b_desc1: got %h expected 0104", desc_log[1]); end
      n_checks++; if (wr_log.size() != 2 || wr_log[0] !== {8'd0, 32'hA0A1A2A3} || wr_log[1] !== {8'd1, 32'hB0B1B2B3}) begin n_fail++; $display("FAIL b2b_writes: got n=%0d first=%h expected 2 / 00a0a1a2a3", wr_log.size(), wr_log[0]); end
   endtask

   task automatic test_full_wrap;
      do_reset();
      bus.rd_ptr = 8'd0;
      bus.desc_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 252; i++) send_byte(8'(i), (i == 251));
         wait_idle();
      end
      for (int i = 0; i < 4; i++) send_byte(8'(i), (i == 3));
      wait_idle();
      #1;
      wr_log.delete();
      desc_log.delete();
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_free2_ready: got %b expected 1", bus.in_ready); end
      send_byte(8'h10, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h13, 1'b0);
      n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr_wr !== 8'd253) begin n_fail++; $display("FAIL full_write253: got en=%b addr=%0d expected 1/253", bus.mem_wr_en, bus.mem_addr_wr); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_free1_ready: got %b expected 0", bus.in_ready); end
      bus.in_data = 8'h14; bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++; if (bus.in_ready !== 1'b0 || bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL full_stall_%0d: got ready=%b wr_en=%b expected 0/0", k, bus.in_ready, bus.mem_wr_en); end
      end
      bus.rd_ptr = 8'd8;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_restore_ready: got %b expected 1", bus.in_ready); end
      for (int i = 0; i < 8; i++) send_byte(8'h14 + 8'(i), 1'b0);
      send_byte(8'h1C, 1'b1);
      wait_idle();
      bus.desc_ready = 1'b0;
      #1;
      n_checks++; if (wr_log.size() != 4) begin n_fail++; $display("FAIL full_write_count: got %0d expected 4", wr_log.size()); end
      n_checks++; if (wr_log[1] !== {8'd254, 32'h14151617} || wr_log[2] !== {8'd255, 32'h18191A1B}) begin n_fail++; $display("FAIL full_write_254_255: got %h %h expected fe14151617 ff18191a1b", wr_log[1], wr_log[2]); end
      n_checks++; if (wr_log[3] !== {8'd0, 32'h1C000000}) begin n_fail++; $display("FAIL full_wrap_to_0: got %h expected 001c000000", wr_log[3]); end
      n_checks++; if (desc_log[0] !== {8'd253, 8'd13}) begin n_fail++; $display("FAIL full_desc: got %h expected fd0d", desc_log[0]); end
   endtask

   task automatic test_desc_hold;
      wr_log.delete();
      bus.desc_ready = 1'b0;
      send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b1);
      n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr_wr !== 8'd1 || bus.mem_data !== 32'hAABBCC00) begin n_fail++; $display("FAIL hold_partial_word: got en=%b addr=%0d data=%h expected 1/1/aabbcc00", bus.mem_wr_en, bus.mem_addr_wr, bus.mem_data); end
      @(negedge clk);
      bus.in_data = 8'h55; bus.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         n_checks++; if (bus.desc_valid !== 1'b1 || bus.desc_start !== 8'd1 || bus.desc_len !== 8'd3) begin n_fail++; $display("FAIL hold_desc_%0d: got v=%b start=%0d len=%0d expected 1/1/3", k, bus.desc_valid, bus.desc_start, bus.desc_len); end
         n_checks++; if (bus.desc_csum !== exp_csum(16'h76BC)) begin n_fail++; $display("FAIL hold_csum_%0d: got %h expected %h", k, bus.desc_csum, exp_csum(16'h76BC)); end
         n_checks++; if (bus.in_ready !== 1'b0 || bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL hold_quiet_%0d: got ready=%b wr_en=%b expected 0/0", k, bus.in_ready, bus.mem_wr_en); end
         @(negedge clk);
      end
      bus.desc_ready = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_handshake_ready: got %b expected 0", bus.in_ready); end
      @(negedge clk);
      n_checks++; if (dbg_state !== ST_IDLE || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_after_release: got state=%0d ready=%b expected 0/1", dbg_state, bus.in_ready); end
      @(negedge clk);
      n_checks++; if (dbg_state !== ST_RECV || bus.desc_start !== 8'd2) begin n_fail++; $display("FAIL hold_next_packet: got state=%0d start=%0d expected 1/2", dbg_state, bus.desc_start); end
      send_byte(8'h66, 1'b1);
      wait_idle();
      bus.desc_ready = 1'b0;
      #1;
      n_checks++; if (wr_log.size() != 2 || wr_log[1] !== {8'd2, 32'h55660000}) begin n_fail++; $display("FAIL hold_next_write: got n=%0d last=%h expected 2 / 0255660000", wr_log.size(), wr_log[1]); end
   endtask

   task automatic test_reset_mid;
      bus.rd_ptr = 8'd0;
      for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i), 1'b0);
      reset = 1'b1;
      #1;
      wr_log.delete();
      desc_log.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_checks++; if (bus.mem_wr_en !== 1'b0 || bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet_%0d: got wr_en=%b desc_valid=%b expected 0/0", k, bus.mem_wr_en, bus.desc_valid); end
         @(negedge clk);
      end
      n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL midreset_no_write: got %0d expected 0", wr_log.size()); end
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b1);
      n_checks++; if (bus.mem_addr_wr !== 8'd0 || bus.mem_data !== 32'h11220000) begin n_fail++; $display("FAIL midreset_write: got addr=%0d data=%h expected 0/11220000", bus.mem_addr_wr, bus.mem_data); end
      @(negedge clk);
      n_checks++; if (bus.desc_valid !== 1'b1 || bus.desc_start !== 8'd0 || bus.desc_len !== 8'd2) begin n_fail++; $display("FAIL midreset_desc: got v=%b start=%0d len=%0d expected 1/0/2", bus.desc_valid, bus.desc_start, bus.desc_len); end
      n_checks++; if (bus.desc_csum !== exp_csum(16'h1122)) begin n_fail++; $display("FAIL midreset_csum: got %h expected %h", bus.desc_csum, exp_csum(16'h1122)); end
      bus.desc_ready = 1'b1;
      @(negedge clk);
      bus.desc_ready = 1'b0;
   endtask

   task automatic test_saturate;
      bus.rd_ptr = 8'd1;
      #1;
      wr_log.delete();
      for (int i = 0; i < 258; i++) send_byte(8'(i), (i == 257));
      n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr_wr !== 8'd64 || bus.mem_data !== 32'hFCFDFE00) begin n_fail++; $display("FAIL sat_last_word: got en=%b addr=%0d data=%h expected 1/64/fcfdfe00", bus.mem_wr_en, bus.mem_addr_wr, bus.mem_data); end
      @(negedge clk);
      n_checks++; if (bus.desc_valid !== 1'b1 || bus.desc_start !== 8'd1 || bus.desc_len !== 8'd255) begin n_fail++; $display("FAIL sat_desc: got v=%b start=%0d len=%0d expected 1/1/255", bus.desc_valid, bus.desc_start, bus.desc_len); end
      n_checks++; if (bus.desc_csum !== exp_csum(16'hBF40)) begin n_fail++; $display("FAIL sat_csum: got %h expected %h", bus.desc_csum, exp_csum(16'hBF40)); end
      bus.desc_ready = 1'b1;
      @(negedge clk);
      bus.desc_ready = 1'b0;
      #1;
      n_checks++; if (wr_log.size() != 64) begin n_fail++; $display("FAIL sat_write_count: got %0d expected 64", wr_log.size()); end
   endtask

   // Test sequence and report.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      cnt_en   = 1'b0;
      rdy_low  = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_full_wrap();
      test_desc_hold();
      test_reset_mid();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/buffer_writer.md
BUFFER_WRITER -- requirements
Module: buffer_writer

Interface
REQ-001 Parameter: ADDR_W, 14, word-address width of the packet buffer RAM (32-bit words).
REQ-002 Parameter: LEN_W, 16, width of the descriptor byte-length field.
REQ-003 Port: clk  in  1  clock; all logic on posedge clk.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: in_data  in  8  ingress byte, network order.
REQ-006 Port: in_valid / in_last  in  1 each  byte valid; last byte of packet.
REQ-007 Port: in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-008 Port: mem_addr_wr  out  ADDR_W  buffer RAM write address.
REQ-009 Port: mem_data  out  32  buffer RAM write data.
REQ-010 Port: mem_wr_en  out  1  buffer RAM write strobe, one cycle per word.
REQ-011 Port: rd_ptr  in  ADDR_W  consumer's next-unread word address, for free-space calculation.
REQ-012 Port: desc_start / desc_len  out  ADDR_W / LEN_W  first word address; packet byte count.
REQ-013 Port: desc_csum  out  16  packet checksum (see Configuration).
REQ-014 Port: desc_valid / desc_ready  out / in  1 each  descriptor handshake.

Function
REQ-015 FSM states SHALL be IDLE, RECV, DESC; the byte accepted in IDLE moves to RECV; an accepted in_last moves to DESC.
REQ-016 Bytes SHALL pack big-endian: byte 0 of a word -> [31:24], byte 3 -> [7:0].
REQ-017 Word completed by accepted byte in cycle N SHALL produce mem_wr_en=1 in cycle N+1 with mem_addr_wr=wr_ptr; wr_ptr increments mod 2^ADDR_W after the write.
REQ-018 in_last on a partial word SHALL write that word in cycle N+1, unused low bytes zero.
REQ-019 desc_valid SHALL rise in cycle N+2 after in_last acceptance and hold desc_start/desc_len/desc_csum stable until desc_valid & desc_ready; then FSM -> IDLE.
REQ-020 desc_start SHALL equal wr_ptr at the packet's first byte; the next packet starts at the word after the previous packet's last word.
REQ-021 Used words = (wr_ptr - rd_ptr) mod 2^ADDR_W; in_ready=1 only in IDLE/RECV when free = 2^ADDR_W - 1 - used >= 2.
REQ-022 in_ready SHALL be 0 in DESC; bytes presented in the handshake cycle are not accepted until the following cycle.
REQ-023 Byte count SHALL saturate at 2^LEN_W-1; bytes beyond it are accepted and discarded (no RAM write) until in_last.
REQ-024 in_last without in_valid SHALL be ignored.

Reset
REQ-025 On reset: FSM=IDLE, wr_ptr=0, byte lane=0, in_ready=0 in the reset cycle, mem_wr_en=0, mem_addr_wr=0, mem_data=0, desc_valid=0, desc_start=0, desc_len=0, desc_csum=0.
REQ-026 Reset mid-packet or mid-descriptor SHALL discard the partial packet; no write or descriptor follows.

Configuration
REQ-027 Macro BUFFER_WRITER_CSUM_EN defined: desc_csum = 16-bit one's-complement sum (end-around carry) of the packet bytes as big-endian 16-bit words, odd trailing byte zero-padded, not inverted.
REQ-028 Macro BUFFER_WRITER_CSUM_EN undefined: no checksum logic; desc_csum tied to 0.

Verification
REQ-029 Bytes 01 02 03 04 05 (last) from reset -> writes 0x01020304 @0, 0x05000000 @1; desc start=0 len=5; csum=0x0906 (macro on).
REQ-030 Two back-to-back 4-byte packets, desc_ready held 1 -> second desc_start=1; in_ready low for exactly the DESC cycles.
REQ-031 rd_ptr=0, wr_ptr=16381 -> in_ready drops with free=1; raising rd_ptr to 8 restores in_ready; write at 16383 wraps to 0.
REQ-032 desc_ready held 0 for 10 cycles -> desc fields stable, in_ready=0 throughout, no writes.
REQ-033 reset pulse after 6 bytes of a packet -> no further mem_wr_en, desc_valid=0, next packet desc_start=0.
